// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with valid/ready handshakes.
// Compares CHUNK bits per cycle and stops at the first differing chunk.
module seq_magnitude_comparator #(
  parameter  int WIDTH = 16,
  parameter  int CHUNK = 4,
  localparam int CW    = $clog2(WIDTH / CHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             greater,
  output logic             less,
  output logic [CW-1:0]    chunks,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    chunks_q, chunks_d;

  logic [WIDTH-1:0] sign_mask;
  logic [CHUNK-1:0] ca, cb;

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = is_signed;
  end

  always_comb begin
    ca = '0;
    cb = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        ca = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        cb = b_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    chunks_d = chunks_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a ^ sign_mask;
          b_d     = b ^ sign_mask;
          k_d     = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (ca != cb) begin
          eq_d     = 1'b0;
          gt_d     = (ca > cb);
          lt_d     = (ca < cb);
          chunks_d = CW'(k_q) + CW'(1);
          state_d  = DONE;
        end else if (k_q == KW'(N - 1)) begin
          eq_d     = 1'b1;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          chunks_d = CW'(N);
          state_d  = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      chunks_q <= chunks_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign equal     = eq_q;
  assign greater   = gt_q;
  assign less      = lt_q;
  assign chunks    = chunks_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             greater;
  logic             less;
  logic [CW-1:0]    chunks;
  logic             busy;

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [5:0] res;  // {equal, greater, less, chunks}
    int         lat;
  } exp_t;

  exp_t sb[$];

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .equal     (equal),
    .greater   (greater),
    .less      (less),
    .chunks    (chunks),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s);
    exp_t             e;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    ch;
    logic             gt, lt;
    d  = x ^ y;
    ch = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (d[i*CHUNK +: CHUNK] != '0) ch = CW'(N - i);
    end
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    e.res = {x == y, gt, lt, ch};
    e.lat = int'(ch);
    return e;
  endfunction

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    sb.push_back(model(x, y, s));
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    a         = x;
    b         = y;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    acc_cyc = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL issue_busy: got %b want 1", busy);
    end
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   n;
    logic saved;
    e = sb.pop_front();
    n = 0;
    while (out_valid !== 1'b1 && n < N + 4) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: out_valid got %b want 1", name, out_valid);
    end else begin
      total++;
      if ({equal, greater, less, chunks} !== e.res) begin
        bad++;
        $display("FAIL %s_result: got eq/gt/lt/ch=%b want %b", name,
                 {equal, greater, less, chunks}, e.res);
      end
      total++;
      if (cyc - acc_cyc != e.lat) begin
        bad++;
        $display("FAIL %s_latency: got %0d want %0d", name, cyc - acc_cyc, e.lat);
      end
    end
    saved     = out_ready;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = saved;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL %s_after_take: got valid/ready/busy=%b want 010", name,
               {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, equal, greater, less, chunks, busy, in_ready} !== 9'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {out_valid, equal, greater, less,
               chunks, busy, in_ready});
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    issue(16'h1234, 16'h1234, 1'b0); collect("u_equal");
    issue(16'h9000, 16'h1FFF, 1'b0); collect("u_greater_c1");
    issue(16'h12F0, 16'h12E0, 1'b0); collect("u_greater_c3");
    issue(16'h0001, 16'h0002, 1'b0); collect("u_less_c4");
  endtask

  task automatic test_signed;
    issue(16'h9000, 16'h1FFF, 1'b1); collect("s_less_c1");
    issue(16'h8000, 16'h7FFF, 1'b1); collect("s_min_max");
    issue(16'hFFFF, 16'hFFFE, 1'b1); collect("s_greater_c4");
    issue(16'h7FFF, 16'h8000, 1'b1); collect("s_max_min");
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] x, y;
    int               c;
    for (int i = 0; i < 8; i++) begin
      x = WIDTH'($urandom);
      y = x;
      c = $urandom_range(0, N - 1);
      y[c*CHUNK +: CHUNK] = CHUNK'($urandom);
      issue(x, y, 1'($urandom_range(0, 1)));
      collect("random");
    end
  endtask

  task automatic test_back_to_back;
    int acc1;
    out_ready = 1'b1;
    issue(16'h0A00, 16'h0B00, 1'b0);
    acc1 = acc_cyc;
    collect("b2b_first");
    issue(16'h4444, 16'h4445, 1'b0);
    total++;
    if (acc_cyc - acc1 != 2 + 2) begin
      bad++;
      $display("FAIL b2b_period: got %0d want %0d", acc_cyc - acc1, 4);
    end
    collect("b2b_second");
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   n;
    issue(16'h5555, 16'h5554, 1'b0);
    e = sb.pop_front();
    n = 0;
    while (out_valid !== 1'b1 && n < N + 4) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_timeout: out_valid got %b want 1", out_valid);
    end
    a         = 16'h00FF;
    b         = 16'h0100;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    sb.push_back(model(16'h00FF, 16'h0100, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, busy, equal, greater, less, chunks} !== {3'b101, e.res}) begin
        bad++;
        $display("FAIL bp_hold: got %b want %b", {out_valid, in_ready, busy, equal,
                 greater, less, chunks}, {3'b101, e.res});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      bad++;
      $display("FAIL bp_take: got valid/ready/busy=%b want 010", {out_valid, in_ready, busy});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    acc_cyc = cyc;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_new_accept: busy got %b want 1", busy);
    end
    collect("bp_new");
  endtask

  task automatic test_reset_mid_cmp;
    logic seen;
    issue(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, equal, greater, less, chunks, busy, in_ready} !== 9'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want 0", {out_valid, equal, greater, less,
               chunks, busy, in_ready});
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_result: got out_valid seen=%b want 0", seen);
    end
    issue(16'h1234, 16'h1235, 1'b0);
    collect("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_cmp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
